// File: rtl/axis_slave_fifo.sv
// AXI4-Stream slave that buffers one frame at a time in a FIFO, which the MLP then reads out word by word.
// Optional macro AXIS_SLAVE_TSTRB_MASK_EN zeroes each byte whose TSTRB bit is clear before the beat is stored.
module axis_slave_fifo #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_DEPTH           = 16
) (
    input  logic                              S_AXIS_ACLK,
    input  logic                              S_AXIS_ARESETN,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
    input  logic                              S_AXIS_TLAST,
    input  logic                              S_AXIS_TVALID,
    output logic                              S_AXIS_TREADY,
    input  logic                              pi_read_from_fifo,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   po_mlp_data,
    output logic                              po_mlp_data_valid,
    output logic                              po_mlp_last,
    output logic                              po_fifo_empty,
    output logic                              po_rd_fifo_done
);

    localparam int W  = C_S_AXIS_TDATA_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_DRAIN
    } state_t;

    state_t          state, state_next;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_next;
    logic            wr_en, rd_en, full;
    logic            tready_next, done_next;
    logic [W-1:0]    wr_data;
    logic [W:0]      rd_word;
    logic [W:0]      mem [FIFO_DEPTH];

    assign full    = (count == CW'(FIFO_DEPTH));
    // The full guard is redundant with a registered TREADY, but keeps a
    // simultaneous read from ever letting a write land on an occupied slot.
    assign wr_en   = S_AXIS_TVALID && S_AXIS_TREADY && !full;
    assign rd_en   = pi_read_from_fifo && (count != '0);
    assign rd_word = mem[rd_ptr];

`ifdef AXIS_SLAVE_TSTRB_MASK_EN
    always_comb begin
        wr_data = S_AXIS_TDATA;
        for (int b = 0; b < W/8; b++) begin
            if (!S_AXIS_TSTRB[b]) wr_data[8*b +: 8] = 8'h00;
        end
    end
`else
    logic unused_tstrb;
    assign unused_tstrb = ^S_AXIS_TSTRB;
    assign wr_data      = S_AXIS_TDATA;
`endif

    // NOTE: storage has no reset; the pointers and count define which entries are valid.
    always_ff @(posedge S_AXIS_ACLK) begin
        if (wr_en) mem[wr_ptr] <= {S_AXIS_TLAST, wr_data};
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        count_next = count + CW'(wr_en) - CW'(rd_en);
        case (state)
            S_IDLE: begin
                if (wr_en) state_next = S_AXIS_TLAST ? S_DRAIN : S_RECV;
            end
            S_RECV: begin
                if (wr_en && S_AXIS_TLAST) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (rd_en && rd_word[W]) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
        tready_next = (state_next != S_DRAIN) && (count_next < CW'(FIFO_DEPTH));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state             <= S_IDLE;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            S_AXIS_TREADY     <= 1'b0;
            po_mlp_data       <= '0;
            po_mlp_data_valid <= 1'b0;
            po_mlp_last       <= 1'b0;
            po_fifo_empty     <= 1'b1;
            po_rd_fifo_done   <= 1'b0;
        end else begin
            state             <= state_next;
            count             <= count_next;
            S_AXIS_TREADY     <= tready_next;
            po_mlp_data_valid <= rd_en;
            po_fifo_empty     <= (count_next == '0);
            po_rd_fifo_done   <= done_next;
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) begin
                rd_ptr      <= rd_ptr + AW'(1);
                po_mlp_data <= rd_word[W-1:0];
                po_mlp_last <= rd_word[W];
            end
        end
    end

endmodule

// File: tb/tb_axis_slave_fifo.sv
// Self-checking bench for axis_slave_fifo: directed scenarios plus random traffic against a queue-based model.
module tb_axis_slave_fifo;

    localparam int W = 32;
    localparam int D = 16;
`ifdef AXIS_SLAVE_TSTRB_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [W-1:0]   tdata;
    logic [W/8-1:0] tstrb;
    logic           tlast, tvalid, tready, rd;
    logic [W-1:0]   mlp_data;
    logic           mlp_valid, mlp_last, fifo_empty, rd_done;

    always #5 clk = ~clk;

    axis_slave_fifo #(.C_S_AXIS_TDATA_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .S_AXIS_ACLK      (clk),
        .S_AXIS_ARESETN   (rst_n),
        .S_AXIS_TDATA     (tdata),
        .S_AXIS_TSTRB     (tstrb),
        .S_AXIS_TLAST     (tlast),
        .S_AXIS_TVALID    (tvalid),
        .S_AXIS_TREADY    (tready),
        .pi_read_from_fifo(rd),
        .po_mlp_data      (mlp_data),
        .po_mlp_data_valid(mlp_valid),
        .po_mlp_last      (mlp_last),
        .po_fifo_empty    (fifo_empty),
        .po_rd_fifo_done  (rd_done)
    );

    // Reference model: a queue of stored beats plus the observable output state.
    typedef struct {
        logic         last;
        logic [W-1:0] data;
    } beat_t;

    beat_t        mq[$];
    logic         m_tready, m_drain, m_valid, m_last, m_empty, m_done;
    logic [W-1:0] m_data;
    int           checks = 0;
    int           errors = 0;

    function automatic logic [W-1:0] stored_value(input logic [W-1:0] d, input logic [W/8-1:0] s);
        logic [W-1:0] r;
        r = d;
        for (int b = 0; b < W/8; b++) begin
            if (MASK_EN && !s[b]) r[8*b +: 8] = 8'h00;
        end
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_tready = 1'b0; m_drain = 1'b0; m_valid = 1'b0;
        m_last   = 1'b0; m_empty = 1'b1; m_done  = 1'b0;
        m_data   = '0;
    endtask

    task automatic model_tick();
        beat_t w;
        bit    accept, do_read;
        accept  = tvalid && m_tready;
        do_read = rd && (mq.size() > 0);
        m_valid = 1'b0;
        m_done  = 1'b0;
        if (do_read) begin
            w       = mq.pop_front();
            m_data  = w.data;
            m_last  = w.last;
            m_valid = 1'b1;
            if (w.last) begin
                m_done  = 1'b1;
                m_drain = 1'b0;
            end
        end
        if (accept) begin
            w.data = stored_value(tdata, tstrb);
            w.last = tlast;
            mq.push_back(w);
            if (tlast) m_drain = 1'b1;
        end
        m_tready = !m_drain && (mq.size() < D);
        m_empty  = (mq.size() == 0);
    endtask

    // One clock: advance the model with the driven inputs and compare all outputs #1 after the edge.
    task automatic step();
        @(posedge clk);
        model_tick();
        #1;
        checks += 6;
        if (tready !== m_tready) begin
            errors++; $display("FAIL tready t=%0t got %b expected %b", $time, tready, m_tready);
        end
        if (mlp_valid !== m_valid) begin
            errors++; $display("FAIL data_valid t=%0t got %b expected %b", $time, mlp_valid, m_valid);
        end
        if (mlp_data !== m_data) begin
            errors++; $display("FAIL mlp_data t=%0t got %h expected %h", $time, mlp_data, m_data);
        end
        if (mlp_last !== m_last) begin
            errors++; $display("FAIL mlp_last t=%0t got %b expected %b", $time, mlp_last, m_last);
        end
        if (fifo_empty !== m_empty) begin
            errors++; $display("FAIL fifo_empty t=%0t got %b expected %b", $time, fifo_empty, m_empty);
        end
        if (rd_done !== m_done) begin
            errors++; $display("FAIL rd_done t=%0t got %b expected %b", $time, rd_done, m_done);
        end
    endtask

    task automatic idle_inputs();
        tvalid = 1'b0; tlast = 1'b0; rd = 1'b0;
        tdata  = '0;   tstrb = '1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks += 5;
        if (tready !== 1'b0)     begin errors++; $display("FAIL reset_tready got %b expected 0", tready); end
        if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b expected 1", fifo_empty); end
        if (mlp_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got %b expected 0", mlp_valid); end
        if (mlp_data !== '0)     begin errors++; $display("FAIL reset_data got %h expected 0", mlp_data); end
        if ({mlp_last, rd_done} !== 2'b00) begin
            errors++; $display("FAIL reset_last_done got %b expected 00", {mlp_last, rd_done});
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (tready !== 1'b1) begin errors++; $display("FAIL tready_after_release got %b expected 1", tready); end
    endtask

    task automatic test_frame();
        logic [W-1:0] words[4];
        int           dones = 0;
        words = '{32'h0, 32'hC, 32'h18, 32'h24};
        for (int i = 0; i < 4; i++) begin
            tvalid = 1'b1; tdata = words[i]; tlast = (i == 3);
            step();
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            rd = 1'b1;
            step();
            if (rd_done === 1'b1) dones++;
            checks += 2;
            if (mlp_data !== words[i]) begin
                errors++; $display("FAIL frame_word%0d got %h expected %h", i, mlp_data, words[i]);
            end
            if (mlp_last !== (i == 3)) begin
                errors++; $display("FAIL frame_last%0d got %b expected %b", i, mlp_last, (i == 3));
            end
        end
        rd = 1'b0;
        step();
        if (rd_done === 1'b1) dones++;
        checks += 2;
        if (dones != 1)      begin errors++; $display("FAIL frame_done_pulses got %0d expected 1", dones); end
        if (tready !== 1'b1) begin errors++; $display("FAIL frame_back_idle tready got %b expected 1", tready); end
    endtask

    task automatic test_empty_read();
        logic [W-1:0] held;
        held = mlp_data;
        rd   = 1'b1;
        step();
        rd = 1'b0;
        checks += 2;
        if (mlp_valid !== 1'b0) begin errors++; $display("FAIL empty_read_valid got %b expected 0", mlp_valid); end
        if (mlp_data !== held)  begin errors++; $display("FAIL empty_read_data got %h expected %h", mlp_data, held); end
        step();
    endtask

    task automatic test_tstrb();
        logic [W-1:0] exp;
        exp    = MASK_EN ? 32'h00BB00DD : 32'hAABBCCDD;
        tvalid = 1'b1; tdata = 32'hAABBCCDD; tstrb = 4'b0101; tlast = 1'b1;
        step();
        idle_inputs();
        rd = 1'b1;
        step();
        rd = 1'b0;
        checks++;
        if (mlp_data !== exp) begin errors++; $display("FAIL tstrb_data got %h expected %h", mlp_data, exp); end
        step();
    endtask

    task automatic test_simultaneous();
        int words_out = 0;
        int cyc       = 0;
        for (int i = 0; i < 5; i++) begin
            tvalid = 1'b1; tdata = $urandom; tlast = 1'b0;
            step();
        end
        for (int i = 0; i < 10; i++) begin
            tvalid = 1'b1; tdata = $urandom; rd = 1'b1;
            step();
            checks++;
            if (fifo_empty !== 1'b0) begin errors++; $display("FAIL simul_empty cycle %0d got %b expected 0", i, fifo_empty); end
        end
        tvalid = 1'b1; tdata = $urandom; tlast = 1'b1; rd = 1'b0;
        step();
        idle_inputs();
        rd = 1'b1;
        while (cyc < 30) begin
            step();
            cyc++;
            if (mlp_valid === 1'b1) words_out++;
            if (rd_done === 1'b1) break;
        end
        rd = 1'b0;
        checks++;
        if (words_out != 6) begin errors++; $display("FAIL simul_words got %0d expected 6", words_out); end
        step();
    endtask

    task automatic test_random();
        int cyc = 0;
        for (int i = 0; i < 1500; i++) begin
            tvalid = ($urandom_range(0, 3) != 0);
            tdata  = $urandom;
            tstrb  = 4'($urandom);
            tlast  = ($urandom_range(0, 7) == 0);
            rd     = ($urandom_range(0, 2) != 0);
            step();
        end
        // Close any open frame, then drain it.
        idle_inputs();
        while (!m_empty || m_drain) begin
            if (cyc >= 100) begin
                errors++; $display("FAIL random_drain_timeout queued %0d", mq.size());
                break;
            end
            tvalid = !m_drain; tlast = 1'b1; rd = m_drain;
            step();
            cyc++;
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 3; i++) begin
            tvalid = 1'b1; tdata = 32'h100 + i; tlast = 1'b0;
            step();
        end
        idle_inputs();
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        checks += 3;
        if (tready !== 1'b0)     begin errors++; $display("FAIL midreset_tready got %b expected 0", tready); end
        if (fifo_empty !== 1'b1) begin errors++; $display("FAIL midreset_empty got %b expected 1", fifo_empty); end
        if (rd_done !== 1'b0)    begin errors++; $display("FAIL midreset_done got %b expected 0", rd_done); end
        @(posedge clk);
        #2 rst_n = 1'b1;
        step();
        checks++;
        if (tready !== 1'b1) begin errors++; $display("FAIL midreset_release tready got %b expected 1", tready); end
        rd = 1'b1;
        repeat (4) step();
        rd = 1'b0;
    endtask

    task automatic test_full();
        int accepted = 0;
        for (int i = 0; i < 20; i++) begin
            tvalid = 1'b1; tdata = $urandom; tlast = 1'b0;
            if (tready === 1'b1) accepted++;
            step();
        end
        checks += 2;
        if (accepted != 16)  begin errors++; $display("FAIL full_accepted got %0d expected 16", accepted); end
        if (tready !== 1'b0) begin errors++; $display("FAIL full_tready got %b expected 0", tready); end
        rd = 1'b1;
        if (tready === 1'b1) accepted++;
        step();
        rd = 1'b0;
        checks++;
        if (accepted != 16) begin errors++; $display("FAIL full_read_cycle accepted %0d expected 16", accepted); end
        if (tready === 1'b1) accepted++;
        step();
        checks += 2;
        if (accepted != 17)  begin errors++; $display("FAIL full_17th accepted %0d expected 17", accepted); end
        if (tready !== 1'b0) begin errors++; $display("FAIL full_refill_tready got %b expected 0", tready); end
        idle_inputs();
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        test_reset();
        test_frame();
        test_empty_read();
        test_tstrb();
        test_simultaneous();
        test_random();
        test_reset_mid_frame();
        test_reset();
        test_full();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_slave_fifo.md
AXIS_SLAVE_FIFO -- requirements
Module: axis_slave_fifo

Interface
REQ-001 The block SHALL have parameter C_S_AXIS_TDATA_WIDTH, default 32, setting the stream data width in bits.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 16, setting the number of FIFO entries (power of two, >=2).
REQ-003 S_AXIS_ACLK  input  1  single clock for all logic.
REQ-004 S_AXIS_ARESETN  input  1  reset, asynchronous assertion, active-low.
REQ-005 S_AXIS_TDATA  input  C_S_AXIS_TDATA_WIDTH  stream data.
REQ-006 S_AXIS_TSTRB  input  C_S_AXIS_TDATA_WIDTH/8  byte qualifiers.
REQ-007 S_AXIS_TLAST  input  1  marks the final beat of a frame.
REQ-008 S_AXIS_TVALID  input  1  upstream beat valid.
REQ-009 S_AXIS_TREADY  output  1  block can accept a beat.
REQ-010 pi_read_from_fifo  input  1  MLP read request, one word per cycle.
REQ-011 po_mlp_data  output  C_S_AXIS_TDATA_WIDTH  word read out to the MLP.
REQ-012 po_mlp_data_valid  output  1  po_mlp_data holds a newly read word.
REQ-013 po_mlp_last  output  1  TLAST flag stored with the current po_mlp_data word.
REQ-014 po_fifo_empty  output  1  FIFO holds no words.
REQ-015 po_rd_fifo_done  output  1  one-cycle pulse when the last word of a frame is read out.

Function
REQ-016 A beat SHALL be accepted only on a rising edge with S_AXIS_TVALID=1 and S_AXIS_TREADY=1; it is written as {TLAST, data} at the write pointer.
REQ-017 S_AXIS_TREADY SHALL be registered and SHALL not depend combinationally on S_AXIS_TVALID.
REQ-018 FSM states SHALL be S_IDLE, S_RECV and S_DRAIN.
REQ-019 S_IDLE: TREADY=1; first accepted beat moves to S_RECV, or directly to S_DRAIN if that beat has TLAST=1.
REQ-020 S_RECV: TREADY=1 while the count after the current cycle is below FIFO_DEPTH, else 0; an accepted beat with TLAST=1 moves to S_DRAIN.
REQ-021 S_DRAIN: TREADY=0; when the word with the stored last flag is read out, po_rd_fifo_done pulses and the FSM returns to S_IDLE in the same cycle.
REQ-022 Full: the FIFO SHALL never be written while count==FIFO_DEPTH, even when a read occurs in the same cycle; the freed slot is offered on the next cycle.
REQ-023 Read: when pi_read_from_fifo=1 and count>0, po_mlp_data and po_mlp_last SHALL be updated one cycle later with po_mlp_data_valid=1 for that cycle.
REQ-024 Empty: pi_read_from_fifo with count==0 SHALL be ignored; po_mlp_data_valid=0 and pointers unchanged.
REQ-025 Simultaneous write and read with 0<count<FIFO_DEPTH SHALL leave count unchanged; with count==0, only the write takes effect.
REQ-026 Read and write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be $clog2(FIFO_DEPTH)+1 bits wide.
REQ-027 po_fifo_empty SHALL be registered and equal (count==0).
REQ-028 po_mlp_data SHALL hold its last value when no read occurs.

Reset
REQ-029 While S_AXIS_ARESETN=0: FSM=S_IDLE, pointers=0, count=0, S_AXIS_TREADY=0, po_mlp_data=0, po_mlp_data_valid=0, po_mlp_last=0, po_fifo_empty=1, po_rd_fifo_done=0.
REQ-030 S_AXIS_TREADY SHALL rise on the first rising edge after reset release.
REQ-031 Reset mid-frame SHALL discard all stored words; no po_rd_fifo_done is issued for the discarded frame.

Configuration
REQ-032 Macro AXIS_SLAVE_TSTRB_MASK_EN, when defined, SHALL zero each byte whose S_AXIS_TSTRB bit is 0 before it is stored.
REQ-033 Without AXIS_SLAVE_TSTRB_MASK_EN, S_AXIS_TSTRB SHALL be ignored and data stored unchanged.

Verification
REQ-034 Reset mid-frame after 3 beats accepted -> po_fifo_empty=1, TREADY=0 during reset, TREADY=1 one edge after release, no po_rd_fifo_done.
REQ-035 Frame 0x0,0xC,0x18,0x24 with TLAST on 0x24, then 4 reads -> same words in order, po_mlp_last=1 only with 0x24, po_rd_fifo_done pulses once, FSM back in S_IDLE.
REQ-036 TVALID held high for 20 beats, no reads, FIFO_DEPTH=16 -> exactly 16 accepted, TREADY=0 afterward; 1 read -> 17th beat accepted on the cycle after next.
REQ-037 Read pulse while empty -> po_mlp_data_valid stays 0, po_mlp_data unchanged.
REQ-038 Beat 0xAABBCCDD with TSTRB=4'b0101 -> stored 0x00BB00DD with macro defined, 0xAABBCCDD without.
REQ-039 Simultaneous write and read at count=5 for 10 cycles -> count stays 5, data in order across pointer wrap-around.
